// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit for the EX stage.
// One shift-add (multiply) or restoring-divide step per clock, followed by a
// single sign-correction cycle that writes HI/LO and pulses done.
// HI/LO can also be written directly (MTHI/MTLO) while the unit is idle.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] busA,
    input  logic [WIDTH-1:0] busB,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 is_div_q, is_div_d;
    logic                 sign_a_q, sign_a_d;
    logic                 sign_b_q, sign_b_d;
    // a: |multiplicand| or |dividend|; b: |multiplier| (shifted) or |divisor|
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    // Multiply: running product. Divide: {remainder, quotient}.
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 done_q, done_d;

    logic                 last_iter;
    logic                 in_neg_a;
    logic                 in_neg_b;
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       rem_sh;
    logic                 q_bit;
    logic [WIDTH-1:0]     rem_next;
    logic [2*WIDTH-1:0]   prod;

    // Two's-complement negate when n is set (sign correction / magnitude).
    function automatic logic [WIDTH-1:0] fix_sign_w(input logic [WIDTH-1:0] x,
                                                    input logic n);
        return n ? -x : x;
    endfunction

    function automatic logic [2*WIDTH-1:0] fix_sign_2w(input logic [2*WIDTH-1:0] x,
                                                       input logic n);
        return n ? -x : x;
    endfunction

    assign last_iter = (count_q == CW'(WIDTH - 1));

    // State and datapath registers; reset clears everything and aborts any op.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            is_div_q <= 1'b0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            is_div_q <= is_div_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    // Next-state: IDLE -> RUN on start, WIDTH iterations, one FIX cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last_iter) state_d = FIX;
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: operand capture, per-bit iteration, sign fix and HI/LO writes.
    always_comb begin
        count_d  = count_q;
        is_div_d = is_div_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;

        // op[0]=0 selects the signed variants
        in_neg_a = ~op[0] & busA[WIDTH-1];
        in_neg_b = ~op[0] & busB[WIDTH-1];

        // Multiply step: add multiplicand into the upper half if the current
        // multiplier bit is set; the carry is kept and shifted back in.
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (b_q[0] ? {1'b0, a_q} : '0);

        // Divide step: shifted remainder needs WIDTH+1 bits before the trial
        // subtract; the kept remainder always fits back into WIDTH bits.
        rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
        q_bit    = (rem_sh >= {1'b0, b_q});
        rem_next = q_bit ? (rem_sh[WIDTH-1:0] - b_q) : rem_sh[WIDTH-1:0];

        prod     = fix_sign_2w(acc_q, sign_a_q ^ sign_b_q);

        case (state_q)
            IDLE: begin
                if (start) begin
                    // start takes priority over a same-cycle MTHI/MTLO
                    is_div_d = op[1];
                    sign_a_d = in_neg_a;
                    sign_b_d = in_neg_b;
                    a_d      = fix_sign_w(busA, in_neg_a);
                    b_d      = fix_sign_w(busB, in_neg_b);
                    acc_d    = op[1] ? {{WIDTH{1'b0}}, fix_sign_w(busA, in_neg_a)} : '0;
                    count_d  = '0;
                end else begin
                    if (hi_we) hi_d = wdata;
                    if (lo_we) lo_d = wdata;
                end
            end
            RUN: begin
                count_d = count_q + CW'(1);
                if (is_div_q) begin
                    acc_d = {rem_next, acc_q[WIDTH-2:0], q_bit};
                end else begin
                    acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                    b_d   = b_q >> 1;
                end
            end
            FIX: begin
                done_d = 1'b1;
                if (!is_div_q) begin
                    hi_d = prod[2*WIDTH-1:WIDTH];
                    lo_d = prod[WIDTH-1:0];
                end else if (b_q == '0) begin
                    // Divide by zero: raw dividend back in HI, all ones in LO
                    hi_d = fix_sign_w(a_q, sign_a_q);
                    lo_d = '1;
                end else begin
                    // Remainder follows the dividend's sign
                    lo_d = fix_sign_w(acc_q[WIDTH-1:0], sign_a_q ^ sign_b_q);
                    hi_d = fix_sign_w(acc_q[2*WIDTH-1:WIDTH], sign_a_q);
                end
            end
            default: ;
        endcase
    end

    // Outputs: busy for RUN and FIX, registered done pulse, HI/LO registers.
    always_comb begin
        busy = (state_q != IDLE);
        done = done_q;
        hi   = hi_q;
        lo   = lo_q;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative integer multiply/divide unit in the EX stage.
- Consumes the register file's busA/busB read data and produces the HI/LO results used by MFHI/MFLO.
- Shift-add multiplication and restoring division, one bit per cycle, behind a start/busy/done handshake.
- Also accepts direct MTHI/MTLO writes.

Parameters:
- WIDTH, 32, operand width; iteration count equals WIDTH.

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  request a new operation; sampled only in IDLE
- op  in  2  0=MULT (signed), 1=MULTU, 2=DIV (signed), 3=DIVU
- busA  in  WIDTH  operand A (multiplicand / dividend), register file rs read
- busB  in  WIDTH  operand B (multiplier / divisor), register file rt read
- hi_we  in  1  MTHI write enable
- lo_we  in  1  MTLO write enable
- wdata  in  WIDTH  MTHI/MTLO data
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse: hi/lo hold a new result
- hi  out  WIDTH  HI register (mult upper half / remainder)
- lo  out  WIDTH  LO register (mult lower half / quotient)

Behaviour:
- Reset: state=IDLE; busy=0, done=0, hi=0, lo=0; internal counter and operands cleared. A reset asserted mid-operation aborts the operation; no result is written.
- States: IDLE, RUN, FIX.
- IDLE, start=1 at edge E0:
  - Latch op and the operand signs.
  - Latch |busA| and |busB| for signed ops, raw values for unsigned ops.
  - Clear the accumulator and count=0; go to RUN; busy=1 after E0.
- RUN: one iteration per edge for WIDTH edges (E1..E32 at default).
  - Multiply: conditional add of the multiplicand into the 2*WIDTH accumulator, then shift right one.
  - Divide: shift the remainder:quotient pair left one, trial-subtract the divisor, keep the result if non-negative and set the quotient bit.
  - After the iteration with count=WIDTH-1, go to FIX.
- FIX (edge E33 at default):
  - Apply sign correction.
    - MULT: negate the 64-bit product if the operand signs differ.
    - DIV: negate the quotient if the signs differ; the remainder takes the dividend's sign.
  - Write hi/lo; go to IDLE.
  - busy=0 and done=1 for exactly the cycle after E33.
- Latency: hi/lo valid and done high WIDTH+1 edges after the start edge. Back-to-back: start may be asserted in the done cycle and is accepted.
- done is 0 in all other cycles. MTHI/MTLO writes do not pulse done.
- start while busy=1: ignored; no queuing.
- hi_we/lo_we:
  - Taken only in IDLE when start=0; the write is visible the next cycle.
  - Ignored while busy.
  - If start=1 in the same IDLE cycle, start wins and the write is dropped.
  - hi_we and lo_we may be asserted together.
- Divide by zero (busB=0, DIV or DIVU): same latency; hi=busA as latched (raw dividend), lo=all ones (0xFFFFFFFF).
- Signed overflow (DIV 0x80000000 / 0xFFFFFFFF): lo=0x80000000, hi=0, no trap.
- hi/lo hold their values while busy; they change only at the FIX edge, an MTHI/MTLO write, or reset.
- busA/busB are sampled only at the start edge; later changes have no effect.

Test Plan:
- MULTU 0xFFFFFFFF * 0xFFFFFFFF -> done 33 cycles after the start edge; hi=0xFFFFFFFE, lo=0x00000001; busy high for exactly 33 cycles.
- MULT 0xFFFFFFFD (-3) * 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; MULT 0x80000000 * 0x80000000 -> hi=0x40000000, lo=0.
- DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIVU 100 / 7 -> lo=14, hi=2.
  - DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
  - DIVU 5 / 0 -> hi=5, lo=0xFFFFFFFF.
- start pulsed again at cycle 10 of a running op, with busA/busB changed -> ignored; the original result appears at cycle 33; done pulses exactly once.
- hi_we with wdata=0x12345678 in IDLE -> hi=0x12345678 next cycle, done stays 0.
  - hi_we during RUN -> hi unchanged.
  - start+lo_we in the same cycle -> lo gets the operation result only.
- Reset asserted at cycle 15 of a DIV -> next cycle busy=0, done=0, hi=lo=0; a new MULTU 3*4 then completes normally with lo=12, hi=0.
